// File: rtl/arbitro_pkg.sv
// Shared constants for the two-input byte arbiter: default widths, grant encoding,
// reset grant history and the round-robin grant helper.
package arbitro_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int FIFO_AW_DEF    = 2;

    localparam logic GNT_IN0 = 1'b0;
    localparam logic GNT_IN1 = 1'b1;

    // Reset history points at input 1 so input 0 takes the first grant.
    localparam logic LAST_GRANT_RST = GNT_IN1;

    function automatic logic rr_pick(input logic i_nempty0,
                                     input logic i_nempty1,
                                     input logic i_last);
        logic w_pick;
        if (i_nempty0 && i_nempty1) begin
            w_pick = ~i_last;
        end else if (i_nempty1) begin
            w_pick = GNT_IN1;
        end else begin
            w_pick = GNT_IN0;
        end
        return w_pick;
    endfunction

endpackage

// File: rtl/fifo_sinc_ochobits.sv
// Small synchronous FIFO holding one requester's bytes; head is visible on dout
// without a pop, so the arbiter can load it on the same edge it pops.
module fifo_sinc_ochobits
    import arbitro_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int AW     = FIFO_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;

    logic w_do_push;
    logic w_do_pop;

    // A full FIFO refuses the push even when it is popped on the same edge.
    assign w_do_push = push && (r_count != C_FULL);
    assign w_do_pop  = pop  && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == C_FULL);
    assign empty = (r_count == '0);

endmodule

// File: rtl/arbitro_mux2a1_ochobits.sv
// Two-input byte arbiter driving the 8-bit 2:1 mux with a registered output stage.
// Round-robin by default; define ARB_PRIO_FIJA_EN for fixed priority to input 0.
module arbitro_mux2a1_ochobits
    import arbitro_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int FIFO_AW    = FIFO_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid0,
    input  logic [DATA_W-1:0] data_in0,
    output logic              ready0,
    input  logic              valid1,
    input  logic [DATA_W-1:0] data_in1,
    output logic              ready1,
    input  logic              out_ready,
    output logic              validout,
    output logic [DATA_W-1:0] dataout,
    output logic              selector,
    output logic [1:0]        err_ovf
);

    logic              w_full0,  w_full1;
    logic              w_empty0, w_empty1;
    logic [DATA_W-1:0] w_head0,  w_head1;
    logic              w_push0,  w_push1;
    logic              w_pop0,   w_pop1;
    logic              w_load;
    logic              w_gnt_valid;
    logic              w_gnt;
    logic [DATA_W-1:0] w_mux_byte;

    logic              r_validout;
    logic [DATA_W-1:0] r_dataout;
    logic              r_selector;
    logic              r_last_grant;
    logic [1:0]        r_err_ovf;

    assign w_push0 = valid0 && !w_full0;
    assign w_push1 = valid1 && !w_full1;

    fifo_sinc_ochobits #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .AW     (FIFO_AW)
    ) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (w_push0),
        .din   (data_in0),
        .pop   (w_pop0),
        .dout  (w_head0),
        .full  (w_full0),
        .empty (w_empty0)
    );

    fifo_sinc_ochobits #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .AW     (FIFO_AW)
    ) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (w_push1),
        .din   (data_in1),
        .pop   (w_pop1),
        .dout  (w_head1),
        .full  (w_full1),
        .empty (w_empty1)
    );

    // The output register only accepts a new byte when it is empty or being drained.
    assign w_load = !r_validout || out_ready;

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt       = GNT_IN0;
        if (w_load && (!w_empty0 || !w_empty1)) begin
            w_gnt_valid = 1'b1;
`ifdef ARB_PRIO_FIJA_EN
            w_gnt = w_empty0 ? GNT_IN1 : GNT_IN0;
`else
            w_gnt = rr_pick(!w_empty0, !w_empty1, r_last_grant);
`endif
        end
    end

    assign w_pop0     = w_gnt_valid && (w_gnt == GNT_IN0);
    assign w_pop1     = w_gnt_valid && (w_gnt == GNT_IN1);
    assign w_mux_byte = (w_gnt == GNT_IN1) ? w_head1 : w_head0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_validout   <= 1'b0;
            r_dataout    <= '0;
            r_selector   <= GNT_IN0;
            r_last_grant <= LAST_GRANT_RST;
            r_err_ovf    <= 2'b00;
        end else begin
            if (w_load) begin
                if (w_gnt_valid) begin
                    r_validout   <= 1'b1;
                    r_dataout    <= w_mux_byte;
                    r_selector   <= w_gnt;
                    r_last_grant <= w_gnt;
                end else begin
                    r_validout <= 1'b0;
                end
            end
            r_err_ovf <= r_err_ovf | {valid1 && w_full1, valid0 && w_full0};
        end
    end

    assign ready0   = !w_full0;
    assign ready1   = !w_full1;
    assign validout = r_validout;
    assign dataout  = r_dataout;
    assign selector = r_selector;
    assign err_ovf  = r_err_ovf;

endmodule

// File: tb/tb_arbitro_mux2a1_ochobits.sv
// Directed bench for arbitro_mux2a1_ochobits; build with +define+ARB_PRIO_FIJA_EN
// to check the fixed-priority variant.
module tb_arbitro_mux2a1_ochobits;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid0, valid1, out_ready;
    logic [7:0] data_in0, data_in1;
    logic       ready0, ready1, validout, selector;
    logic [7:0] dataout;
    logic [1:0] err_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    arbitro_mux2a1_ochobits dut (
        .clk       (clk),
        .reset     (reset),
        .valid0    (valid0),
        .data_in0  (data_in0),
        .ready0    (ready0),
        .valid1    (valid1),
        .data_in1  (data_in1),
        .ready1    (ready1),
        .out_ready (out_ready),
        .validout  (validout),
        .dataout   (dataout),
        .selector  (selector),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [7:0] exp_d [6];
    logic       exp_s [6];

    initial begin
        reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0; out_ready = 1'b0;
        data_in0 = 8'h00; data_in1 = 8'h00;

        // reset state
        tick(); tick();
        check("rst_validout", 16'(validout), 16'h0);
        check("rst_dataout",  16'(dataout),  16'h00);
        check("rst_selector", 16'(selector), 16'h0);
        check("rst_ready",    16'({ready1, ready0}), 16'h3);
        check("rst_err",      16'(err_ovf),  16'h0);
        reset = 1'b0;

        // single source
        out_ready = 1'b1;
        valid0 = 1'b1; data_in0 = 8'hA1;
        tick();
        check("ss_early_valid", 16'(validout), 16'h0);
        data_in0 = 8'hA2;
        tick();
        check("ss_d1",   16'({validout, selector, dataout}), 16'h2A1);
        valid0 = 1'b0;
        tick();
        check("ss_d2",   16'({validout, selector, dataout}), 16'h2A2);
        tick();
        check("ss_drop", 16'({validout, dataout}), 16'h0A2);

        // round-robin
        do_reset();
        out_ready = 1'b0;
        valid0 = 1'b1; data_in0 = 8'h10; valid1 = 1'b1; data_in1 = 8'h20;
        tick();
        data_in0 = 8'h11; data_in1 = 8'h21;
        tick();
        check("rr_first", 16'({validout, selector, dataout}), 16'h210);
        valid0 = 1'b0; valid1 = 1'b0;
        tick();
        check("rr_hold",  16'({validout, selector, dataout}), 16'h210);
        out_ready = 1'b1;
        tick();
        check("rr_second", 16'({validout, selector, dataout}), 16'h320);
        tick();
        check("rr_third",  16'({validout, selector, dataout}), 16'h211);
        tick();
        check("rr_fourth", 16'({validout, selector, dataout}), 16'h321);
        tick();
        check("rr_idle",   16'(validout), 16'h0);

        // backpressure, full, overflow
        do_reset();
        out_ready = 1'b0;
        valid1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in1 = 8'h30 + 8'(i);
            tick();
            if (i == 4) check("bp_ready1_full", 16'(ready1), 16'h0);
        end
        valid1 = 1'b0;
        check("bp_head",  16'({validout, selector, dataout}), 16'h330);
        check("bp_err",   16'(err_ovf), 16'h2);
        check("bp_ready", 16'({ready1, ready0}), 16'h1);
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            check("bp_drain", 16'({validout, selector, dataout}), 16'h330 + 16'(i));
        end
        tick();
        check("bp_empty",  16'(validout), 16'h0);
        check("bp_sticky", 16'(err_ovf), 16'h2);

        // reset mid-stream
        out_ready = 1'b0;
        valid0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in0 = 8'h40 + 8'(i);
            tick();
        end
        valid0 = 1'b0;
        check("mr_loaded", 16'({validout, dataout}), 16'h140);
        reset = 1'b1;
        tick();
        check("mr_validout", 16'(validout), 16'h0);
        check("mr_err",      16'(err_ovf),  16'h0);
        check("mr_dataout",  16'(dataout),  16'h00);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_no_stale", 16'(validout), 16'h0);
        end

        // both backlogged, three bytes each
        do_reset();
        out_ready = 1'b0;
        valid0 = 1'b1; valid1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in0 = 8'h50 + 8'(i);
            data_in1 = 8'h60 + 8'(i);
            tick();
        end
        valid0 = 1'b0; valid1 = 1'b0;
`ifdef ARB_PRIO_FIJA_EN
        exp_d[0] = 8'h50; exp_d[1] = 8'h51; exp_d[2] = 8'h52;
        exp_d[3] = 8'h60; exp_d[4] = 8'h61; exp_d[5] = 8'h62;
        exp_s[0] = 1'b0;  exp_s[1] = 1'b0;  exp_s[2] = 1'b0;
        exp_s[3] = 1'b1;  exp_s[4] = 1'b1;  exp_s[5] = 1'b1;
`else
        exp_d[0] = 8'h50; exp_d[1] = 8'h60; exp_d[2] = 8'h51;
        exp_d[3] = 8'h61; exp_d[4] = 8'h52; exp_d[5] = 8'h62;
        exp_s[0] = 1'b0;  exp_s[1] = 1'b1;  exp_s[2] = 1'b0;
        exp_s[3] = 1'b1;  exp_s[4] = 1'b0;  exp_s[5] = 1'b1;
`endif
        check("bl_out0", 16'({validout, selector, dataout}), {7'd0, 1'b1, exp_s[0], exp_d[0]});
        out_ready = 1'b1;
        for (int i = 1; i < 6; i++) begin
            tick();
            check("bl_out", 16'({validout, selector, dataout}), {7'd0, 1'b1, exp_s[i], exp_d[i]});
        end
        tick();
        check("bl_idle", 16'(validout), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
